// File: rtl/alu_issue_seq_pkg.sv
// Shared types for the ALU issue/writeback sequencer: ALU opcodes, the
// sequencer FSM states, and instruction-field widths.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_SLL = 3'd2,
        ALU_LSR = 3'd3,
        ALU_AND = 3'd4,
        ALU_OR  = 3'd5,
        ALU_XOR = 3'd6,
        ALU_EQL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issue_state_e;

    // Instruction word is {ld_imm, op, rd, rs1, rs2}.
    function automatic int instr_w(input int aw);
        return 1 + OP_W + 3 * aw;
    endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Instruction, ALU and result handshake bundle for alu_issue_seq.
// zero_o exists only when ALU_ISSUE_ZFLAG_EN is defined.
interface alu_issue_seq_if #(
    parameter int NREGS = 4
);
    localparam int REG_AW  = $clog2(NREGS);
    localparam int INSTR_W = alu_pkg::instr_w(REG_AW);

    logic               instr_valid_i;
    logic               instr_ready_o;
    logic [INSTR_W-1:0] instr_i;
    logic [7:0]         imm_i;
    logic [7:0]         alu_a_o;
    logic [7:0]         alu_b_o;
    logic [2:0]         alu_op_o;
    logic [7:0]         alu_res_i;
    logic               res_valid_o;
    logic               res_ready_i;
    logic [7:0]         res_o;
    logic [REG_AW-1:0]  res_rd_o;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic               zero_o;

    modport slave (
        input  instr_valid_i, instr_i, imm_i, alu_res_i, res_ready_i,
        output instr_ready_o, alu_a_o, alu_b_o, alu_op_o, res_valid_o,
               res_o, res_rd_o, zero_o
    );

    modport master (
        output instr_valid_i, instr_i, imm_i, alu_res_i, res_ready_i,
        input  instr_ready_o, alu_a_o, alu_b_o, alu_op_o, res_valid_o,
               res_o, res_rd_o, zero_o
    );
`else
    modport slave (
        input  instr_valid_i, instr_i, imm_i, alu_res_i, res_ready_i,
        output instr_ready_o, alu_a_o, alu_b_o, alu_op_o, res_valid_o,
               res_o, res_rd_o
    );

    modport master (
        output instr_valid_i, instr_i, imm_i, alu_res_i, res_ready_i,
        input  instr_ready_o, alu_a_o, alu_b_o, alu_op_o, res_valid_o,
               res_o, res_rd_o
    );
`endif

endinterface

// File: rtl/alu_issue_seq_regfile.sv
// Small register file: NREGS x 8 flops, two combinational read ports,
// one synchronous write port, asynchronous active-high clear.
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NREGS];

    // Storage: cleared by reset, otherwise written on the single write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer in front of the 8-bit simple ALU.
// Accepts one instruction, presents its operands to the ALU for one cycle,
// captures the result (or immediate), writes it back and holds it on the
// result handshake. Optional zero flag: define ALU_ISSUE_ZFLAG_EN.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter  int NREGS  = 4,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_issue_seq_if.slave bus
);

    issue_state_e      state;
    logic              ld_imm_q;
    logic [REG_AW-1:0] rd_q;
    logic [7:0]        imm_q;

    logic              in_ld_imm;
    alu_op_e           in_op;
    logic [REG_AW-1:0] in_rd;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [7:0]        rdata_a;
    logic [7:0]        rdata_b;
    logic [7:0]        wb_data;
    logic              wb_en;

    assign in_rs2    = bus.instr_i[REG_AW-1:0];
    assign in_rs1    = bus.instr_i[2*REG_AW-1:REG_AW];
    assign in_rd     = bus.instr_i[3*REG_AW-1:2*REG_AW];
    assign in_op     = alu_op_e'(bus.instr_i[3*REG_AW+2:3*REG_AW]);
    assign in_ld_imm = bus.instr_i[3*REG_AW+3];

    // Writeback happens only on the EXEC edge; a reset during EXEC kills it.
    assign wb_en   = (state == EXEC);
    assign wb_data = ld_imm_q ? imm_q : bus.alu_res_i;

    alu_regfile #(
        .NREGS(NREGS)
    ) u_regfile (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we      (wb_en),
        .waddr   (rd_q),
        .wdata   (wb_data),
        .raddr_a (in_rs1),
        .raddr_b (in_rs2),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // Sequencer FSM: operands are latched at accept, so they are read before
    // this instruction's own writeback and stay stable through EXEC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= IDLE;
            ld_imm_q          <= 1'b0;
            rd_q              <= '0;
            imm_q             <= '0;
            bus.instr_ready_o <= 1'b1;
            bus.res_valid_o   <= 1'b0;
            bus.alu_a_o       <= '0;
            bus.alu_b_o       <= '0;
            bus.alu_op_o      <= '0;
            bus.res_o         <= '0;
            bus.res_rd_o      <= '0;
`ifdef ALU_ISSUE_ZFLAG_EN
            bus.zero_o        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.instr_valid_i) begin
                        state             <= EXEC;
                        bus.instr_ready_o <= 1'b0;
                        ld_imm_q          <= in_ld_imm;
                        rd_q              <= in_rd;
                        imm_q             <= bus.imm_i;
                        bus.alu_a_o       <= rdata_a;
                        bus.alu_b_o       <= rdata_b;
                        bus.alu_op_o      <= in_op;
                    end
                end
                EXEC: begin
                    state           <= RESP;
                    bus.res_valid_o <= 1'b1;
                    bus.res_o       <= wb_data;
                    bus.res_rd_o    <= rd_q;
`ifdef ALU_ISSUE_ZFLAG_EN
                    bus.zero_o      <= (wb_data == 8'h00);
`endif
                end
                RESP: begin
                    if (bus.res_ready_i) begin
                        state             <= IDLE;
                        bus.res_valid_o   <= 1'b0;
                        bus.instr_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state             <= IDLE;
                    bus.res_valid_o   <= 1'b0;
                    bus.instr_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed self-checking bench for alu_issue_seq with a behavioural model of
// the simple ALU closing the loop. Zero-flag checks run when
// ALU_ISSUE_ZFLAG_EN is defined.
module tb_alu_issue_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_issue_seq_if #(.NREGS(4)) bus ();

    alu_issue_seq #(.NREGS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Simple ALU model driven by the sequencer's operand outputs.
    always_comb begin
        bus.alu_res_i = 8'h00;
        case (alu_op_e'(bus.alu_op_o))
            ALU_ADD: bus.alu_res_i = bus.alu_a_o + bus.alu_b_o;
            ALU_SUB: bus.alu_res_i = bus.alu_a_o - bus.alu_b_o;
            ALU_SLL: bus.alu_res_i = bus.alu_a_o << bus.alu_b_o;
            ALU_LSR: bus.alu_res_i = bus.alu_a_o >> bus.alu_b_o;
            ALU_AND: bus.alu_res_i = bus.alu_a_o & bus.alu_b_o;
            ALU_OR:  bus.alu_res_i = bus.alu_a_o | bus.alu_b_o;
            ALU_XOR: bus.alu_res_i = bus.alu_a_o ^ bus.alu_b_o;
            ALU_EQL: bus.alu_res_i = {7'b0, bus.alu_a_o == bus.alu_b_o};
            default: bus.alu_res_i = 8'h00;
        endcase
    end

    function automatic logic [9:0] mk(input logic ld, input logic [2:0] op,
                                      input logic [1:0] rd, input logic [1:0] rs1,
                                      input logic [1:0] rs2);
        return {ld, op, rd, rs1, rs2};
    endfunction

    // Runs one instruction end to end and reports what was observed.
    task automatic issue(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                         output logic [7:0] a, output logic [7:0] b,
                         output logic v_exec, output logic v_resp,
                         output logic [7:0] res, output logic [1:0] res_rd,
                         output logic z, output logic rdy_after);
        int waited = 0;
        while (bus.instr_ready_o !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 10) begin
            checks++; failures++;
            $display("[TB] FAIL ready_timeout got=%b want=1", bus.instr_ready_o);
        end
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = mk(ld, op, rd, rs1, rs2);
        bus.imm_i         = imm;
        @(posedge clk); #1;
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = '1;
        bus.imm_i         = 8'hC3;
        a      = bus.alu_a_o;
        b      = bus.alu_b_o;
        v_exec = bus.res_valid_o;
        @(posedge clk); #1;
        v_resp = bus.res_valid_o;
        res    = bus.res_o;
        res_rd = bus.res_rd_o;
`ifdef ALU_ISSUE_ZFLAG_EN
        z = bus.zero_o;
`else
        z = 1'b0;
`endif
        bus.res_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.res_ready_i = 1'b0;
        rdy_after = bus.instr_ready_o;
    endtask

    logic [7:0] a, b, res;
    logic [1:0] rdo;
    logic       ve, vr, z, ra;

    task automatic test_reset();
        rst = 1'b1;
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = '0;
        bus.imm_i         = '0;
        bus.res_ready_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.res_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b want=0", bus.res_valid_o); end
        checks++; if (bus.res_o !== 8'h00) begin failures++; $display("[TB] FAIL rst_res got=%h want=00", bus.res_o); end
        checks++; if (bus.res_rd_o !== 2'd0) begin failures++; $display("[TB] FAIL rst_rd got=%0d want=0", bus.res_rd_o); end
        checks++; if ({bus.alu_a_o, bus.alu_b_o, bus.alu_op_o} !== 19'd0) begin failures++; $display("[TB] FAIL rst_alu got=%h want=0", {bus.alu_a_o, bus.alu_b_o, bus.alu_op_o}); end
`ifdef ALU_ISSUE_ZFLAG_EN
        checks++; if (bus.zero_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_zero got=%b want=0", bus.zero_o); end
`endif
        rst = 1'b0;
        #1;
        checks++; if (bus.instr_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready got=%b want=1", bus.instr_ready_o); end
    endtask

    task automatic test_load_add();
        issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h05, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (res !== 8'h05 || rdo !== 2'd1) begin failures++; $display("[TB] FAIL ld_r1 got=%h/%0d want=05/1", res, rdo); end
        issue(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h03, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (res !== 8'h03 || rdo !== 2'd2) begin failures++; $display("[TB] FAIL ld_r2 got=%h/%0d want=03/2", res, rdo); end
        issue(1'b0, ALU_ADD, 2'd3, 2'd1, 2'd2, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (a !== 8'h05 || b !== 8'h03) begin failures++; $display("[TB] FAIL add_ops got=%h,%h want=05,03", a, b); end
        checks++; if (ve !== 1'b0) begin failures++; $display("[TB] FAIL add_early_valid got=%b want=0", ve); end
        checks++; if (vr !== 1'b1) begin failures++; $display("[TB] FAIL add_valid got=%b want=1", vr); end
        checks++; if (res !== 8'h08 || rdo !== 2'd3) begin failures++; $display("[TB] FAIL add_res got=%h/%0d want=08/3", res, rdo); end
        checks++; if (ra !== 1'b1) begin failures++; $display("[TB] FAIL add_ready_after got=%b want=1", ra); end
    endtask

    task automatic test_sub_eql();
        issue(1'b0, ALU_SUB, 2'd0, 2'd2, 2'd1, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (res !== 8'hFE || rdo !== 2'd0) begin failures++; $display("[TB] FAIL sub_res got=%h/%0d want=FE/0", res, rdo); end
        issue(1'b0, ALU_EQL, 2'd1, 2'd1, 2'd1, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (res !== 8'h01 || rdo !== 2'd1) begin failures++; $display("[TB] FAIL eql_res got=%h/%0d want=01/1", res, rdo); end
    endtask

    task automatic test_sll_hazard();
        issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h05, a, b, ve, vr, res, rdo, z, ra);
        issue(1'b0, ALU_SLL, 2'd1, 2'd1, 2'd2, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (a !== 8'h05 || b !== 8'h03) begin failures++; $display("[TB] FAIL sll_ops got=%h,%h want=05,03", a, b); end
        checks++; if (res !== 8'h28 || rdo !== 2'd1) begin failures++; $display("[TB] FAIL sll_res got=%h/%0d want=28/1", res, rdo); end
        issue(1'b0, ALU_ADD, 2'd3, 2'd1, 2'd0, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (a !== 8'h28) begin failures++; $display("[TB] FAIL sll_fwd got=%h want=28", a); end
        checks++; if (res !== 8'h26) begin failures++; $display("[TB] FAIL sll_next_res got=%h want=26", res); end
    endtask

    task automatic test_backpressure();
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = mk(1'b0, ALU_ADD, 2'd2, 2'd1, 2'd1);
        @(posedge clk); #1;
        bus.instr_i       = mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0);
        bus.imm_i         = 8'hAA;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.res_valid_o !== 1'b1 || bus.res_o !== 8'h50 || bus.res_rd_o !== 2'd2 || bus.instr_ready_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold cyc=%0d got v=%b res=%h rd=%0d rdy=%b want v=1 res=50 rd=2 rdy=0",
                         i, bus.res_valid_o, bus.res_o, bus.res_rd_o, bus.instr_ready_o);
            end
            @(posedge clk); #1;
        end
        bus.instr_valid_i = 1'b0;
        bus.res_ready_i   = 1'b1;
        @(posedge clk); #1;
        bus.res_ready_i   = 1'b0;
        checks++; if (bus.res_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_release got=%b want=0", bus.res_valid_o); end
        issue(1'b0, ALU_ADD, 2'd3, 2'd0, 2'd2, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (a !== 8'hFE || b !== 8'h50) begin failures++; $display("[TB] FAIL bp_not_taken got=%h,%h want=FE,50", a, b); end
        checks++; if (res !== 8'h4E) begin failures++; $display("[TB] FAIL bp_next_res got=%h want=4E", res); end
    endtask

    task automatic test_back_to_back();
        time t0;
        issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h80, a, b, ve, vr, res, rdo, z, ra);
        t0 = $time;
        issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h81, a, b, ve, vr, res, rdo, z, ra);
        issue(1'b0, ALU_ADD, 2'd2, 2'd0, 2'd1, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if ($time - t0 != 60) begin failures++; $display("[TB] FAIL b2b_rate got=%0t want=60", $time - t0); end
        checks++; if (res !== 8'h01) begin failures++; $display("[TB] FAIL b2b_add_wrap got=%h want=01", res); end
        issue(1'b0, ALU_AND, 2'd3, 2'd0, 2'd1, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (res !== 8'h80) begin failures++; $display("[TB] FAIL b2b_and got=%h want=80", res); end
        issue(1'b0, ALU_OR, 2'd3, 2'd0, 2'd1, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (res !== 8'h81) begin failures++; $display("[TB] FAIL b2b_or got=%h want=81", res); end
        issue(1'b0, ALU_LSR, 2'd3, 2'd1, 2'd2, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (res !== 8'h40) begin failures++; $display("[TB] FAIL b2b_lsr got=%h want=40", res); end
    endtask

    task automatic test_reset_mid_exec();
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = mk(1'b1, 3'd0, 2'd2, 2'd1, 2'd1);
        bus.imm_i         = 8'h77;
        @(posedge clk); #1;
        bus.instr_valid_i = 1'b0;
        checks++; if (bus.alu_a_o !== 8'h81) begin failures++; $display("[TB] FAIL mid_pre_ops got=%h want=81", bus.alu_a_o); end
        rst = 1'b1;
        #1;
        checks++; if (bus.res_valid_o !== 1'b0 || bus.res_o !== 8'h00 || bus.res_rd_o !== 2'd0) begin failures++; $display("[TB] FAIL mid_rst_res got v=%b res=%h rd=%0d want 0/00/0", bus.res_valid_o, bus.res_o, bus.res_rd_o); end
        checks++; if ({bus.alu_a_o, bus.alu_b_o, bus.alu_op_o} !== 19'd0) begin failures++; $display("[TB] FAIL mid_rst_alu got=%h want=0", {bus.alu_a_o, bus.alu_b_o, bus.alu_op_o}); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.instr_ready_o !== 1'b1 || bus.res_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_after got rdy=%b v=%b want 1/0", bus.instr_ready_o, bus.res_valid_o); end
        issue(1'b0, ALU_ADD, 2'd0, 2'd1, 2'd2, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (a !== 8'h00 || b !== 8'h00 || res !== 8'h00) begin failures++; $display("[TB] FAIL mid_regs_clear got=%h,%h,%h want=00,00,00", a, b, res); end
        issue(1'b0, ALU_OR, 2'd0, 2'd3, 2'd0, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (a !== 8'h00 || res !== 8'h00) begin failures++; $display("[TB] FAIL mid_r3_clear got=%h,%h want=00,00", a, res); end
    endtask

`ifdef ALU_ISSUE_ZFLAG_EN
    task automatic test_zero_flag();
        issue(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h3C, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (z !== 1'b0) begin failures++; $display("[TB] FAIL zf_ld_nz got=%b want=0", z); end
        issue(1'b0, ALU_XOR, 2'd2, 2'd2, 2'd2, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (res !== 8'h00 || z !== 1'b1) begin failures++; $display("[TB] FAIL zf_xor got=%h/%b want=00/1", res, z); end
        issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h01, a, b, ve, vr, res, rdo, z, ra);
        issue(1'b0, ALU_ADD, 2'd3, 2'd1, 2'd2, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (res !== 8'h01 || z !== 1'b0) begin failures++; $display("[TB] FAIL zf_add got=%h/%b want=01/0", res, z); end
        issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00, a, b, ve, vr, res, rdo, z, ra);
        checks++; if (z !== 1'b1) begin failures++; $display("[TB] FAIL zf_ld_zero got=%b want=1", z); end
    endtask
`endif

    // Main sequence of directed scenarios.
    initial begin
        test_reset();
        test_load_add();
        test_sub_eql();
        test_sll_hazard();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
`ifdef ALU_ISSUE_ZFLAG_EN
        test_zero_flag();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
